icache_responder: RTL and testbench

- Direct-mapped, one-word-per-frame instruction cache.
- Serves the instruction side of the datapath–cache interface: it receives imemREN/imemaddr and returns ihit/imemload.
- On a miss it initiates a single-word read to the memory controller over the iREN/iaddr/iwait/iload port.
- Instantiated in the cache wrapper between the datapath and the memory arbiter.

---
 rtl/icache_responder.sv | 110 +++++++++++
 tb/tb_icache_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame instruction cache.
// Hits are answered combinationally in IDLE; a miss latches the word address and
// issues a single-word read to the memory controller, filling the frame on completion.
module icache_responder #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        flush,
  input  logic        halt,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {StIdle, StFetch} state_e;

  state_e            state_q;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS];
  logic [31:0]       addr_q;
  logic [31:0]       hit_cnt_q;
  logic [31:0]       miss_cnt_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              miss_start;
  logic              fill_done;
  logic              unused_addr_bits;

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign fill_idx = addr_q[IDX_W+1:2];
  assign fill_tag = addr_q[31:IDX_W+2];
  assign unused_addr_bits = ^{imemaddr[1:0], addr_q[1:0]};

  // Hit/miss decode from the registered arrays; flush and halt suppress service.
  always_comb begin
    hit        = 1'b0;
    miss_start = 1'b0;
    fill_done  = 1'b0;
    if (state_q == StIdle) begin
      hit        = imemREN & ~halt & ~flush & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
      miss_start = imemREN & ~halt & ~flush & ~hit;
    end else begin
      // flush beats a completing response: the fill is dropped
      fill_done  = ~iwait & ~flush;
    end
  end

  assign ihit       = hit;
  assign imemload   = hit ? data_q[req_idx] : 32'h0;
  assign iREN       = (state_q == StFetch);
  assign iaddr      = addr_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // Control FSM, valid bits, latched miss address and saturating counters.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      addr_q     <= 32'h0;
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      if (hit && hit_cnt_q != 32'hFFFF_FFFF) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (flush) begin
        state_q <= StIdle;
        valid_q <= '0;
      end else if (state_q == StIdle) begin
        if (miss_start) begin
          state_q <= StFetch;
          addr_q  <= {imemaddr[31:2], 2'b00};
          if (miss_cnt_q != 32'hFFFF_FFFF) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
          end
        end
      end else if (fill_done) begin
        state_q           <= StIdle;
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage; contents are qualified by valid_q so they need no reset.
  always_ff @(posedge CLK) begin
    if (nRST && fill_done) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios followed by random
// traffic, all compared every cycle against a frame-level reference model.
module tb_icache_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        flush;
  logic        halt;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_responder #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
    .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .flush(flush), .halt(halt), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: each frame remembers which word address it holds.
  bit          m_valid [16];
  logic [29:0] m_word  [16];
  logic [31:0] m_data  [16];
  bit          m_busy;
  logic [31:0] m_addr;
  logic [31:0] m_hc;
  logic [31:0] m_mc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit ren, input logic [31:0] a, input bit w, input logic [31:0] ld,
                       input bit fl, input bit hl);
    imemREN = ren; imemaddr = a; iwait = w; iload = ld; flush = fl; halt = hl;
  endtask

  // Compare at the falling edge, then advance the model and the clock.
  task automatic cycle();
    int  idx;
    bit  e_hit;
    @(negedge CLK);
    idx   = int'(imemaddr[5:2]);
    e_hit = !m_busy && imemREN && !halt && !flush && m_valid[idx] && m_word[idx] == imemaddr[31:2];
    chk("ihit",       {31'b0, ihit}, {31'b0, e_hit});
    chk("imemload",   imemload,      e_hit ? m_data[idx] : 32'h0);
    chk("iREN",       {31'b0, iREN}, {31'b0, m_busy});
    chk("iaddr",      iaddr,         m_addr);
    chk("hit_count",  hit_count,     m_hc);
    chk("miss_count", miss_count,    m_mc);
    if (!nRST) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_busy = 0; m_addr = 0; m_hc = 0; m_mc = 0;
    end else if (flush) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_busy = 0;
    end else if (m_busy) begin
      if (!iwait) begin
        m_valid[m_addr[5:2]] = 1;
        m_word[m_addr[5:2]]  = m_addr[31:2];
        m_data[m_addr[5:2]]  = iload;
        m_busy = 0;
      end
    end else if (e_hit) begin
      if (m_hc != 32'hFFFF_FFFF) m_hc = m_hc + 1;
    end else if (imemREN && !halt) begin
      m_busy = 1;
      m_addr = {imemaddr[31:2], 2'b00};
      if (m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
    end
    @(posedge CLK);
    #1;
  endtask

  // One miss that completes after w wait cycles, then the hit cycle.
  task automatic miss_fill(input logic [31:0] a, input int w, input logic [31:0] d);
    drive(1, a, 1, 0, 0, 0); cycle();
    for (int k = 0; k < w; k++) cycle();
    drive(1, a, 0, d, 0, 0); cycle();
    drive(1, a, 1, 0, 0, 0); cycle();
  endtask

  initial begin
    nRST = 0;
    drive(0, 0, 1, 0, 0, 0);
    foreach (m_valid[i]) begin m_valid[i] = 0; m_word[i] = 0; m_data[i] = 0; end
    m_busy = 0; m_addr = 0; m_hc = 0; m_mc = 0;
    @(posedge CLK); #1;
    cycle();
    nRST = 1;
    cycle();

    // Cold miss with three wait cycles
    miss_fill(32'h40, 3, 32'h2001_0005);
    chk("t1_hits",   hit_count,  32'd1);
    chk("t1_misses", miss_count, 32'd1);

    // Hit then conflict on the same frame
    drive(1, 32'h40, 1, 0, 0, 0); cycle();
    miss_fill(32'h80, 0, mem_word(32'h80));
    miss_fill(32'h40, 1, 32'h2001_0005);
    chk("t2_misses", miss_count, 32'd3);

    // Address moves during FETCH; fill still targets the latched address
    drive(1, 32'h44, 1, 0, 0, 0); cycle();
    drive(1, 32'h48, 1, 0, 0, 0); cycle();
    drive(1, 32'h48, 0, 32'hCAFE_0044, 0, 0); cycle();
    miss_fill(32'h48, 0, 32'hCAFE_0048);
    drive(1, 32'h44, 1, 0, 0, 0); cycle();

    // Flush races a completing fill
    drive(1, 32'h4C, 1, 0, 0, 0); cycle();
    drive(1, 32'h4C, 0, 32'hDEAD_004C, 1, 0); cycle();
    miss_fill(32'h4C, 0, 32'hBEEF_004C);

    // Halt suppresses hits and misses
    drive(1, 32'h4C, 1, 0, 0, 1); cycle(); cycle();
    drive(1, 32'h90, 1, 0, 0, 1); cycle();
    drive(1, 32'h4C, 1, 0, 0, 0); cycle();

    // Hit counter saturation
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt_q;
    m_hc = 32'hFFFF_FFFE;
    drive(1, 32'h4C, 1, 0, 0, 0); cycle(); cycle(); cycle(); cycle();
    chk("t6_sat", hit_count, 32'hFFFF_FFFF);

    // Reset in the middle of a fetch with a completing response
    drive(1, 32'h100, 1, 0, 0, 0); cycle();
    nRST = 0; drive(1, 32'h100, 0, 32'h1111_2222, 0, 0); cycle();
    nRST = 1; drive(0, 32'h4C, 1, 0, 0, 0); cycle();
    miss_fill(32'h4C, 0, 32'h3333_4444);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      nRST = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 9) < 8, a, $urandom_range(0, 1) == 1, mem_word(m_addr),
            $urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
